// File: rtl/sync_fifo_mc_pkg.sv
// Shared helpers for the multi-channel synchronous FIFO: derived-width
// functions used as parameter defaults and the per-channel state layout.
package sync_fifo_mc_pkg;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int calc_ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Occupancy width wide enough to hold the value DEPTH itself.
    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 5;

    // Per-channel bookkeeping for the default geometry.
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] wr_ptr;
        logic [DEF_ADDR_W-1:0] rd_ptr;
        logic [DEF_CNT_W-1:0]  count;
    } ch_state_t;

endpackage

// File: rtl/sync_fifo_mc_ch_ctrl.sv
// Per-channel controller: owns write/read pointers and occupancy for one
// queue and derives its four status flags from the registered count.
module sync_fifo_mc_ch_ctrl
    import sync_fifo_mc_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int CNT_W      = calc_cnt_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_acc,
    input  logic                  rd_acc,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rd_ptr,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic                  half_full,
    output logic                  half_empty
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DEPTH / 2);

    logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]      count_d,  count_q;

    // Next-state: pointers advance on accept (natural wrap), count tracks net change.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {ADDR_WIDTH{1'b0}};
            rd_ptr_q <= {ADDR_WIDTH{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr     = wr_ptr_q;
    assign rd_ptr     = rd_ptr_q;
    assign count      = count_q;
    assign full       = (count_q == CNT_FULL);
    assign empty      = (count_q == {CNT_W{1'b0}});
    assign half_full  = (count_q >= CNT_HALF);
    assign half_empty = (count_q <= CNT_HALF);

endmodule

// File: rtl/sync_fifo_mc.sv
// Multi-channel single-clock FIFO: NUM_CH queues statically partitioned in
// one storage array addressed {channel, pointer}, one write and one read port.
module sync_fifo_mc
    import sync_fifo_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_CH     = 4,
    parameter int CH_W       = calc_ch_w(NUM_CH),
    parameter int CNT_W      = calc_cnt_w(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CH_W-1:0]         wr_ch,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    input  logic [CH_W-1:0]         rd_ch,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       empty,
    output logic [NUM_CH-1:0]       half_full,
    output logic [NUM_CH-1:0]       half_empty,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int MEM_AW    = CH_W + ADDR_WIDTH;
    localparam int MEM_WORDS = NUM_CH * DEPTH;

    logic [NUM_CH-1:0]     wr_acc_s;
    logic [NUM_CH-1:0]     rd_acc_s;
    logic [ADDR_WIDTH-1:0] wr_ptr_s [NUM_CH];
    logic [ADDR_WIDTH-1:0] rd_ptr_s [NUM_CH];
    logic [CNT_W-1:0]      cnt_s    [NUM_CH];
    logic                  wr_ok_s;
    logic                  rd_ok_s;
    logic [MEM_AW-1:0]     wr_addr_s;
    logic [MEM_AW-1:0]     rd_addr_s;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [DATA_WIDTH-1:0] rd_data_d,   rd_data_q;
    logic                  rd_valid_d,  rd_valid_q;
    logic                  overflow_d,  overflow_q;
    logic                  underflow_d, underflow_q;

    // Request decode: a channel accepts only when selected, in range and not blocked.
    always_comb begin
        wr_acc_s  = {NUM_CH{1'b0}};
        rd_acc_s  = {NUM_CH{1'b0}};
        wr_addr_s = {MEM_AW{1'b0}};
        rd_addr_s = {MEM_AW{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (wr_ch == CH_W'(c)) && !full[c]) begin
                wr_acc_s[c] = 1'b1;
                wr_addr_s   = {CH_W'(c), wr_ptr_s[c]};
            end else begin
                wr_acc_s[c] = 1'b0;
            end
            if (rd_en && (rd_ch == CH_W'(c)) && !empty[c]) begin
                rd_acc_s[c] = 1'b1;
                rd_addr_s   = {CH_W'(c), rd_ptr_s[c]};
            end else begin
                rd_acc_s[c] = 1'b0;
            end
        end
        wr_ok_s = |wr_acc_s;
        rd_ok_s = |rd_acc_s;
    end

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            sync_fifo_mc_ch_ctrl #(
                .DEPTH      (DEPTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .CNT_W      (CNT_W)
            ) u_ch_ctrl (
                .clk        (clk),
                .rst        (rst),
                .wr_acc     (wr_acc_s[g]),
                .rd_acc     (rd_acc_s[g]),
                .wr_ptr     (wr_ptr_s[g]),
                .rd_ptr     (rd_ptr_s[g]),
                .count      (cnt_s[g]),
                .full       (full[g]),
                .empty      (empty[g]),
                .half_full  (half_full[g]),
                .half_empty (half_empty[g])
            );
            assign count[g*CNT_W +: CNT_W] = cnt_s[g];
        end
    endgenerate

    // Storage write; contents survive reset, pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok_s) begin
            mem_q[wr_addr_s] <= wr_data;
        end
    end

    // Read-side and error-pulse next state; rd_data holds when nothing is read.
    always_comb begin
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_ok_s;
        overflow_d  = wr_en && !wr_ok_s;
        underflow_d = rd_en && !rd_ok_s;
        if (rd_ok_s) begin
            rd_data_d = mem_q[rd_addr_s];
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Output registers; reset wins over any request in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q   <= {DATA_WIDTH{1'b0}};
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_mc.sv
// Directed bench for sync_fifo_mc: per-channel queue model plus a read-data
// scoreboard, all outputs checked one step after every clock edge.
module tb_sync_fifo_mc;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int NCH   = 4;
    localparam int CHW   = 2;
    localparam int CNTW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [CHW-1:0]    wr_ch;
    logic [DW-1:0]     wr_data;
    logic              rd_en;
    logic [CHW-1:0]    rd_ch;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [NCH-1:0]    half_full;
    logic [NCH-1:0]    half_empty;
    logic [NCH*CNTW-1:0] count;
    logic              overflow;
    logic              underflow;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [NCH][$];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_rd;

    always #5 clk = ~clk;

    sync_fifo_mc #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .NUM_CH     (NCH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .empty      (empty),
        .half_full  (half_full),
        .half_empty (half_empty),
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        for (int c = 0; c < NCH; c++) begin
            int n;
            n = mdl[c].size();
            chk($sformatf("count%0d", c), 64'(count[c*CNTW +: CNTW]), 64'(n));
            chk($sformatf("full%0d", c), 64'(full[c]), 64'(n == DEPTH));
            chk($sformatf("empty%0d", c), 64'(empty[c]), 64'(n == 0));
            chk($sformatf("half_full%0d", c), 64'(half_full[c]), 64'(n >= DEPTH / 2));
            chk($sformatf("half_empty%0d", c), 64'(half_empty[c]), 64'(n <= DEPTH / 2));
        end
    endtask

    // One clock of stimulus; expectations come from the model's pre-edge state.
    task automatic cyc(input logic we, input logic [CHW-1:0] wch, input logic [DW-1:0] wd,
                       input logic re, input logic [CHW-1:0] rch);
        logic w_ok;
        logic r_ok;
        w_ok = we && (mdl[wch].size() < DEPTH);
        r_ok = re && (mdl[rch].size() > 0);
        wr_en = we; wr_ch = wch; wr_data = wd;
        rd_en = re; rd_ch = rch;
        if (r_ok) sb.push_back(mdl[rch].pop_front());
        if (w_ok) mdl[wch].push_back(wd);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("rd_valid", 64'(rd_valid), 64'(r_ok));
        if (rd_valid === 1'b1) begin
            if (sb.size() > 0) begin
                last_rd = sb.pop_front();
                chk("rd_data", 64'(rd_data), 64'(last_rd));
            end else begin
                chk("sb_underrun", 64'(sb.size()), 64'd1);
            end
        end else begin
            chk("rd_hold", 64'(rd_data), 64'(last_rd));
        end
        chk("overflow", 64'(overflow), 64'(we && !w_ok));
        chk("underflow", 64'(underflow), 64'(re && !r_ok));
        check_flags();
    endtask

    // Reset cycle, optionally with a read request that reset must swallow.
    task automatic do_reset(input logic re, input logic [CHW-1:0] rch);
        rst = 1'b1; wr_en = 1'b0; rd_en = re; rd_ch = rch;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd_en = 1'b0;
        for (int c = 0; c < NCH; c++) mdl[c].delete();
        sb.delete();
        last_rd = '0;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_underflow", 64'(underflow), 64'd0);
        check_flags();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_data = '0; rd_en = 1'b0; rd_ch = '0;
        last_rd = '0;
        do_reset(1'b0, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
        chk("idle_empty", 64'(empty), 64'hF);
        chk("idle_half_empty", 64'(half_empty), 64'hF);
        chk("idle_full", 64'(full), 64'h0);
        chk("idle_count", 64'(count), 64'h0);

        // Channel 2: fill, overflow on the 17th write, drain in order, then underflow.
        for (int i = 0; i < 17; i++) cyc(1'b1, 2'd2, 32'h100 + 32'(i), 1'b0, 2'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);

        // Interleaved channels.
        cyc(1'b1, 2'd0, 32'hA0, 1'b0, 2'd0);
        cyc(1'b1, 2'd3, 32'hB0, 1'b0, 2'd0);
        cyc(1'b1, 2'd0, 32'hA1, 1'b0, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd3);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);

        // Channel 1 half thresholds: 8, 9, then down to 7, then drain.
        for (int i = 0; i < 9; i++) cyc(1'b1, 2'd1, 32'h200 + 32'(i), 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);

        // Channel 0: steady simultaneous write+read at count 5 across pointer wrap.
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'd0, 32'h400 + 32'(i), 1'b0, 2'd0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 2'd0, 32'h500 + 32'(i), 1'b1, 2'd0);

        // Simultaneous requests at full, then drain and at empty.
        for (int i = 0; i < 11; i++) cyc(1'b1, 2'd0, 32'h600 + 32'(i), 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'd0, 32'h700 + 32'(i), 1'b1, 2'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);
        cyc(1'b1, 2'd0, 32'h800, 1'b1, 2'd0);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd0);

        // Reset while channel 1 holds data and a read is issued.
        for (int i = 0; i < 6; i++) cyc(1'b1, 2'd1, 32'h900 + 32'(i), 1'b0, 2'd0);
        do_reset(1'b1, 2'd1);
        cyc(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
        cyc(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
